// File: rtl/control_chain_initiator.sv
// control_chain_initiator: host-side driver for an ap_ctrl_chain kernel.
// It takes a batch command (run count plus an optional setup phase), starts
// the kernel the requested number of times while keeping at most
// MAX_OUTSTANDING runs unacknowledged, and answers every kernel done with a
// one-cycle continue pulse. It flags protocol violations.
//   ap_clk, ap_rst_n      : clock, asynchronous active-low reset
//   cmd_*                 : batch request handshake (valid/ready, run count, setup)
//   ctrl_*                : outputs to the kernel (ap_start, ap_continue, setup, done)
//   kern_*                : inputs from the kernel (ap_ready, ap_done, ap_idle, start, endian)
//   batch_endian          : kern_endian captured at the first accepted start
//   busy, batch_done      : batch in progress / one-cycle completion pulse
//   runs_issued, runs_done: per-batch accepted starts and acknowledged dones
//   proto_err             : sticky protocol error
module control_chain_initiator #(
    parameter int RUN_W           = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SETUP_CYCLES    = 2
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [RUN_W-1:0] cmd_run_count,
    input  logic             cmd_setup,
    output logic             ctrl_ap_start,
    output logic             ctrl_ap_continue,
    output logic             ctrl_setup,
    output logic             ctrl_done,
    input  logic             kern_ap_ready,
    input  logic             kern_ap_done,
    input  logic             kern_ap_idle,
    input  logic             kern_start,
    input  logic             kern_endian,
    output logic             batch_endian,
    output logic             busy,
    output logic             batch_done,
    output logic [RUN_W-1:0] runs_issued,
    output logic [RUN_W-1:0] runs_done,
    output logic             proto_err
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [5:0] S_RESET = 6'b000001;
    localparam logic [5:0] S_IDLE  = 6'b000010;
    localparam logic [5:0] S_SETUP = 6'b000100;
    localparam logic [5:0] S_ISSUE = 6'b001000;
    localparam logic [5:0] S_DRAIN = 6'b010000;
    localparam logic [5:0] S_DONE  = 6'b100000;
    localparam logic [RUN_W-1:0] RUN_MAX   = '1;
    localparam logic [OUT_W-1:0] OUT_LIM   = OUT_W'(MAX_OUTSTANDING);
    localparam logic [7:0]       SETUP_LIM = 8'(SETUP_CYCLES);

    logic [5:0]       state, state_nx;
    logic [RUN_W-1:0] run_count, issued_nx, done_nx;
    logic [OUT_W-1:0] outstanding, out_nx;
    logic [7:0]       setup_cnt, setup_nx;
    logic             accept, ack, spurious, start_nx;

    assign accept    = ctrl_ap_start && kern_ap_ready;
    assign ack       = kern_ap_done && outstanding != '0;
    assign spurious  = kern_ap_done && outstanding == '0;
    assign issued_nx = accept && runs_issued != RUN_MAX ? runs_issued + 1'b1 : runs_issued;
    assign done_nx   = ack && runs_done != RUN_MAX ? runs_done + 1'b1 : runs_done;
    assign out_nx    = accept && !ack ? outstanding + 1'b1 : !accept && ack ? outstanding - 1'b1 : outstanding;

    // While ap_start is low, a slot freed by a done only re-raises it once the
    // decremented outstanding count is visible in the register, so the start
    // follows the continue pulse by one cycle. While it is high, it drops as
    // soon as the post-update counts reach a limit.
    assign start_nx = state == S_IDLE ? state_nx == S_ISSUE :
                      state_nx == S_ISSUE && issued_nx != run_count && out_nx < OUT_LIM &&
                      (ctrl_ap_start || outstanding < OUT_LIM);

    always_comb begin
        state_nx = state;
        setup_nx = 8'd0;
        if (state == S_RESET)
            state_nx = S_IDLE;
        if (state == S_IDLE && cmd_valid)
            state_nx = cmd_run_count == '0 ? S_DONE : cmd_setup ? S_SETUP : S_ISSUE;
        if (state == S_SETUP) begin
            setup_nx = kern_ap_idle ? setup_cnt + 8'd1 : 8'd0;
            state_nx = setup_nx == SETUP_LIM ? S_ISSUE : S_SETUP;
        end
        if (state == S_ISSUE && issued_nx == run_count)
            state_nx = S_DRAIN;
        if (state == S_DRAIN && runs_done == run_count)
            state_nx = S_DONE;
        if (state == S_DONE)
            state_nx = S_IDLE;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= S_RESET;
            setup_cnt        <= 8'd0;
            run_count        <= '0;
            runs_issued      <= '0;
            runs_done        <= '0;
            outstanding      <= '0;
            cmd_ready        <= 1'b0;
            ctrl_ap_start    <= 1'b0;
            ctrl_ap_continue <= 1'b0;
            ctrl_setup       <= 1'b0;
            ctrl_done        <= 1'b0;
            batch_done       <= 1'b0;
            batch_endian     <= 1'b0;
            busy             <= 1'b0;
            proto_err        <= 1'b0;
        end else begin
            state            <= state_nx;
            setup_cnt        <= setup_nx;
            cmd_ready        <= state_nx == S_IDLE;
            ctrl_setup       <= state_nx == S_SETUP;
            ctrl_ap_start    <= start_nx;
            ctrl_ap_continue <= ack;
            ctrl_done        <= state == S_DONE;
            batch_done       <= state == S_DONE;
            proto_err        <= proto_err || spurious || (accept && !kern_start);
            if (accept && runs_issued == '0)
                batch_endian <= kern_endian;
            if (state == S_IDLE && cmd_valid) begin
                run_count   <= cmd_run_count;
                runs_issued <= '0;
                runs_done   <= '0;
                outstanding <= '0;
                busy        <= 1'b1;
            end else begin
                runs_issued <= issued_nx;
                runs_done   <= done_nx;
                outstanding <= out_nx;
                if (state == S_DONE)
                    busy <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_control_chain_initiator.sv
// tb_control_chain_initiator: self-checking bench for control_chain_initiator.
// Continue pulses and batch completions are checked against scoreboard queues
// filled when the kernel stimulus is driven; cycle timing is checked inline.
module tb_control_chain_initiator;
    localparam int RUN_W = 16;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [RUN_W-1:0] cmd_run_count = '0;
    logic             cmd_setup = 1'b0;
    logic             ctrl_ap_start, ctrl_ap_continue, ctrl_setup, ctrl_done;
    logic             kern_ap_ready = 1'b0;
    logic             kern_ap_done = 1'b0;
    logic             kern_ap_idle = 1'b1;
    logic             kern_start = 1'b1;
    logic             kern_endian = 1'b0;
    logic             batch_endian, busy, batch_done, proto_err;
    logic [RUN_W-1:0] runs_issued, runs_done;

    int checks = 0;
    int errors = 0;
    int acc = 0;
    int base = 0;
    int dsent = 0;
    int exp_cont[$];
    int exp_batch[$];

    control_chain_initiator #(.RUN_W(RUN_W), .MAX_OUTSTANDING(4), .SETUP_CYCLES(2)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_run_count(cmd_run_count), .cmd_setup(cmd_setup),
        .ctrl_ap_start(ctrl_ap_start), .ctrl_ap_continue(ctrl_ap_continue),
        .ctrl_setup(ctrl_setup), .ctrl_done(ctrl_done),
        .kern_ap_ready(kern_ap_ready), .kern_ap_done(kern_ap_done),
        .kern_ap_idle(kern_ap_idle), .kern_start(kern_start), .kern_endian(kern_endian),
        .batch_endian(batch_endian), .busy(busy), .batch_done(batch_done),
        .runs_issued(runs_issued), .runs_done(runs_done), .proto_err(proto_err)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge ap_clk) begin : mon
        int e;
        if (ap_rst_n) begin
            if (ctrl_ap_start && kern_ap_ready)
                acc++;
            if (ctrl_ap_continue) begin
                if (exp_cont.size() == 0)
                    check("cont_unexpected", 64'd1, 64'd0);
                else
                    check("cont_runs_done", 64'(runs_done), 64'(exp_cont.pop_front()));
            end
            if (batch_done) begin
                if (exp_batch.size() == 0)
                    check("batch_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_batch.pop_front();
                    check("batch_issued", 64'(runs_issued), 64'(e));
                    check("batch_runs_done", 64'(runs_done), 64'(e));
                    check("batch_ctrl_done", 64'(ctrl_done), 64'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset;
        ap_rst_n = 1'b0;
        cmd_valid = 1'b0;
        kern_ap_ready = 1'b0;
        kern_ap_done = 1'b0;
        kern_ap_idle = 1'b1;
        kern_start = 1'b1;
        tick;
        tick;
        ap_rst_n = 1'b1;
        tick;
    endtask

    task automatic start_batch(input int n, input logic s);
        base = acc;
        dsent = 0;
        cmd_run_count = RUN_W'(n);
        cmd_setup = s;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    // Behaves like a kernel that is always ready and finishes a run as soon as
    // one is outstanding, until the batch completes or the budget runs out.
    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            if (!busy)
                break;
            kern_ap_ready = 1'b1;
            kern_ap_done = (acc - base) > dsent;
            if (kern_ap_done) begin
                dsent++;
                exp_cont.push_back(dsent);
            end
            tick;
        end
        kern_ap_ready = 1'b0;
        kern_ap_done = 1'b0;
        tick;
        check("drain_busy_low", 64'(busy), 64'd0);
    endtask

    logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        tick;
        check("rst_outputs", 64'({cmd_ready, ctrl_ap_start, ctrl_ap_continue, ctrl_setup, ctrl_done,
              batch_endian, busy, batch_done, runs_issued, runs_done, proto_err}), 64'd0);
        ap_rst_n = 1'b1;
        check("rst_release_ready", 64'(cmd_ready), 64'd0);
        tick;
        check("idle_ready", 64'(cmd_ready), 64'd1);

        // basic single run
        exp_batch.push_back(1);
        start_batch(1, 1'b0);
        check("basic_start_a1", 64'({ctrl_ap_start, busy, cmd_ready}), 64'b110);
        tick;
        check("basic_start_a2", 64'(ctrl_ap_start), 64'd1);
        tick;
        check("basic_start_a3", 64'(ctrl_ap_start), 64'd1);
        kern_ap_ready = 1'b1;
        kern_endian = 1'b1;
        tick;
        kern_ap_ready = 1'b0;
        kern_endian = 1'b0;
        check("basic_start_drop", 64'(ctrl_ap_start), 64'd0);
        check("basic_issued", 64'(runs_issued), 64'd1);
        check("basic_endian", 64'(batch_endian), 64'd1);
        for (int i = 0; i < 4; i++)
            tick;
        kern_ap_done = 1'b1;
        dsent = 1;
        exp_cont.push_back(1);
        tick;
        kern_ap_done = 1'b0;
        check("basic_continue", 64'(ctrl_ap_continue), 64'd1);
        tick;
        check("basic_continue_end", 64'({ctrl_ap_continue, busy, batch_done}), 64'b010);
        tick;
        check("basic_done_pulse", 64'({batch_done, ctrl_done, busy, cmd_ready}), 64'b1101);
        tick;
        check("basic_done_end", 64'(batch_done), 64'd0);

        // setup phase with an idle dropout
        exp_batch.push_back(1);
        kern_ap_idle = 1'b0;
        start_batch(1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            kern_ap_idle = pat[i];
            check("setup_high", 64'({ctrl_setup, ctrl_ap_start}), 64'b10);
            tick;
        end
        kern_ap_idle = 1'b1;
        check("setup_exit_start", 64'({ctrl_setup, ctrl_ap_start}), 64'b01);
        kern_ap_ready = 1'b1;
        tick;
        kern_ap_ready = 1'b0;
        check("setup_issued", 64'({ctrl_ap_start, batch_endian}), 64'b00);
        drain(40);

        // outstanding limit
        exp_batch.push_back(8);
        start_batch(8, 1'b0);
        kern_ap_ready = 1'b1;
        for (int i = 0; i < 6; i++)
            tick;
        check("limit_starts", 64'(acc - base), 64'd4);
        check("limit_start_low", 64'({ctrl_ap_start, runs_issued}), 64'h0004);
        kern_ap_done = 1'b1;
        dsent = 1;
        exp_cont.push_back(1);
        tick;
        kern_ap_done = 1'b0;
        check("limit_cont", 64'({ctrl_ap_continue, ctrl_ap_start}), 64'b10);
        tick;
        check("limit_restart", 64'(ctrl_ap_start), 64'd1);
        drain(60);
        check("limit_total_starts", 64'(acc - base), 64'd8);

        // simultaneous ready and done with two outstanding
        exp_batch.push_back(8);
        start_batch(8, 1'b0);
        kern_ap_ready = 1'b1;
        tick;
        tick;
        kern_ap_done = 1'b1;
        dsent = 1;
        exp_cont.push_back(1);
        tick;
        kern_ap_done = 1'b0;
        check("simul_counts", 64'({runs_issued, runs_done}), 64'h0003_0001);
        for (int i = 0; i < 4; i++)
            tick;
        check("simul_outstanding", 64'({ctrl_ap_start, runs_issued}), 64'h0005);
        drain(60);
        check("no_proto_err", 64'(proto_err), 64'd0);

        // spurious done with nothing outstanding
        kern_ap_done = 1'b1;
        tick;
        kern_ap_done = 1'b0;
        check("spurious_err", 64'({proto_err, ctrl_ap_continue}), 64'b10);
        tick;
        check("spurious_no_cont", 64'({ctrl_ap_continue, runs_done}), 64'd8);
        do_reset;
        check("reset_clears_err", 64'({proto_err, cmd_ready}), 64'b01);

        // ready without the start echo
        exp_batch.push_back(1);
        start_batch(1, 1'b0);
        kern_ap_ready = 1'b1;
        kern_start = 1'b0;
        tick;
        kern_ap_ready = 1'b0;
        kern_start = 1'b1;
        check("nostart_err", 64'({proto_err, runs_issued}), 64'h1_0001);
        drain(40);
        do_reset;

        // zero-run batch
        exp_batch.push_back(0);
        kern_ap_ready = 1'b1;
        start_batch(0, 1'b0);
        check("zero_a1", 64'({batch_done, ctrl_ap_start, busy}), 64'b001);
        tick;
        check("zero_a2", 64'({batch_done, ctrl_ap_start, busy}), 64'b100);
        tick;
        kern_ap_ready = 1'b0;
        check("zero_no_start", 64'(acc - base), 64'd0);

        // reset in the middle of ISSUE
        start_batch(5, 1'b0);
        kern_ap_ready = 1'b1;
        tick;
        tick;
        check("mid_issue", 64'({ctrl_ap_start, runs_issued}), 64'h1_0002);
        #2;
        ap_rst_n = 1'b0;
        kern_ap_ready = 1'b0;
        #1;
        check("async_rst_outputs", 64'({cmd_ready, ctrl_ap_start, ctrl_ap_continue, ctrl_setup, ctrl_done,
              batch_endian, busy, batch_done, runs_issued, runs_done, proto_err}), 64'd0);
        tick;
        tick;
        ap_rst_n = 1'b1;
        check("mid_release_ready", 64'(cmd_ready), 64'd0);
        tick;
        check("mid_idle", 64'({cmd_ready, busy, ctrl_ap_start}), 64'b100);

        tick;
        check("cont_queue_empty", 64'(exp_cont.size()), 64'd0);
        check("batch_queue_empty", 64'(exp_batch.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/control_chain_initiator.md
Name: control_chain_initiator

Overview:
- Host-side driver for the ap_ctrl_chain kernel control interface.
- Accepts a batch command (run count plus optional setup phase) and drives `ap_start`, `ap_continue`, `setup` and `done` toward a kernel.
- Consumes the kernel's `ap_ready`, `ap_done`, `ap_idle`, `start` and `endian`.
- Supports pipelined invocations, with up to MAX_OUTSTANDING runs started but not yet acknowledged.

Parameters:
- RUN_W, 16, width of run count and counters.
- MAX_OUTSTANDING, 4, maximum started-but-unacknowledged runs (1..15).
- SETUP_CYCLES, 2, cycles `kern_ap_idle` must be high during setup before leaving SETUP (1..255).

Ports:
- ap_clk, in, 1, clock.
- ap_rst_n, in, 1, reset.
- cmd_valid, in, 1, batch request.
- cmd_ready, out, 1, initiator can accept a batch.
- cmd_run_count, in, RUN_W, number of kernel runs in the batch.
- cmd_setup, in, 1, perform setup phase before the first start.
- ctrl_ap_start, out, 1, kernel ap_start.
- ctrl_ap_continue, out, 1, kernel ap_continue (1-cycle pulse).
- ctrl_setup, out, 1, kernel setup.
- ctrl_done, out, 1, kernel done (1-cycle pulse at batch end).
- kern_ap_ready, in, 1, kernel accepted a start.
- kern_ap_done, in, 1, kernel finished a run.
- kern_ap_idle, in, 1, kernel idle.
- kern_start, in, 1, kernel start echo; must accompany ap_ready.
- kern_endian, in, 1, kernel endian flag.
- batch_endian, out, 1, kern_endian captured at first accepted start.
- busy, out, 1, batch in progress.
- batch_done, out, 1, 1-cycle pulse when batch completes.
- runs_issued, out, RUN_W, starts accepted in current batch.
- runs_done, out, RUN_W, dones acknowledged in current batch.
- proto_err, out, 1, sticky protocol error.

Behaviour:
- Interface:
  - Single clock `ap_clk`.
  - `ap_rst_n` is asynchronous and active-low.
  - All outputs are registered.
- Reset:
  - State RESET.
  - All outputs 0, except `cmd_ready`=0 until IDLE is entered on the first cycle after reset release.
- Mid-operation reset:
  - Reset mid-batch immediately drops `ctrl_ap_start` and `ctrl_setup`.
  - Counters clear and `proto_err` clears.
- States (one-hot): RESET, IDLE, SETUP, ISSUE, DRAIN, DONE.
- RESET -> IDLE unconditionally.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch run count, clear `runs_issued`, `runs_done` and outstanding, set `busy`=1, drop `cmd_ready`.
  - Run count 0: go to DONE directly; no start is issued.
  - Otherwise: SETUP if `cmd_setup`, else ISSUE.
- SETUP:
  - `ctrl_setup`=1.
  - Counts consecutive cycles with `kern_ap_idle`=1; the count resets when idle drops.
  - At SETUP_CYCLES consecutive cycles: `ctrl_setup`=0 and go to ISSUE.
- ISSUE:
  - `ctrl_ap_start`=1 while `runs_issued` < run count and outstanding < MAX_OUTSTANDING.
  - The cycle `kern_ap_ready`=1 with `ctrl_ap_start`=1:
    - `runs_issued`++ and outstanding++.
    - `ctrl_ap_start` deasserts the next cycle if either limit is now reached; otherwise it stays high (back-to-back starts allowed).
  - `kern_start` low on an accepted ready sets `proto_err`.
  - First accepted start captures `kern_endian` into `batch_endian`.
  - When `runs_issued` == run count: go to DRAIN.
- Done acknowledge (ISSUE and DRAIN):
  - `kern_ap_done`=1 produces `ctrl_ap_continue`=1 on the next cycle, for exactly one cycle.
  - `runs_done`++ and outstanding-- take effect in that same cycle.
  - Consecutive-cycle dones produce consecutive continue pulses.
- Simultaneous accepted ready and done in one cycle: outstanding net unchanged; both counters update.
- `kern_ap_done` with outstanding==0 (any state): set `proto_err`; ignore it (no continue, no count change).
- `kern_ap_ready` while `ctrl_ap_start`=0: ignored.
- DRAIN: once `runs_done` == run count, go to DONE.
- DONE:
  - One cycle: `ctrl_done`=1 and `batch_done`=1.
  - Next cycle: `busy`=0 and go to IDLE.
- Counters:
  - `runs_issued` and `runs_done` saturate at 2^RUN_W-1.
  - Outstanding is log2(MAX_OUTSTANDING+1) bits and never exceeds MAX_OUTSTANDING.
- `cmd_valid` while not IDLE is ignored.
- `proto_err` is sticky until reset.

Test Plan:
- Basic run:
  - Stimulus: run count 1, no setup; kernel ready 2 cycles after start, done 5 cycles later.
  - Required: `ap_start` high exactly until the ready cycle; one continue pulse 1 cycle after done; `ctrl_done`/`batch_done` pulse; `runs_issued`=`runs_done`=1; `busy` falls.
- Setup phase:
  - Stimulus: `cmd_setup`=1, SETUP_CYCLES=2; `kern_ap_idle` pattern 1,0,1,1.
  - Required: `ctrl_setup` high for 4 cycles; first `ap_start` in the cycle after SETUP exits.
- Outstanding limit:
  - Stimulus: run count 8, MAX_OUTSTANDING=4; kernel ready every cycle, done withheld.
  - Required: exactly 4 accepted starts, `ap_start` low afterwards; releasing one done re-raises `ap_start` 1 cycle after the continue pulse; all 8 complete with 8 continue pulses.
- Simultaneous ready and done:
  - Stimulus: ready and done in the same cycle with outstanding=2.
  - Required: outstanding stays 2; `runs_issued` and `runs_done` both increment.
- Protocol errors:
  - Stimulus: done with zero outstanding; separately, ready with `kern_start`=0.
  - Required: `proto_err`=1 in both cases; no continue pulse for the spurious done.
- Edge batches:
  - Stimulus: run count 0.
  - Required: `batch_done` pulses 2 cycles after accept; no `ap_start`.
  - Stimulus: `ap_rst_n` low mid-ISSUE.
  - Required: all outputs 0 asynchronously; IDLE with `cmd_ready`=1 one cycle after release.
